// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; divides stay iterative.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_op1,
    input  logic [XLEN-1:0] req_op2,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic                is_div, sgn1, sgn2, s1, s2, div_zero, div_ovf, fast_go, last;
    logic [XLEN-1:0]     abs1, abs2, special_res, fast_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, prod_s;
    logic [XLEN+1:0]     rem_sh, diff;
    logic [XLEN:0]       rem_n;
    logic [XLEN-1:0]     quo_n, quo_f, rem_f, busy_res;
    logic                qbit;

    assign is_div      = req_op[2];
    assign sgn1        = is_div ? !req_op[0] : (req_op[1:0] != 2'b11);
    assign sgn2        = is_div ? !req_op[0] : !req_op[1];
    assign s1          = sgn1 & req_op1[XLEN-1];
    assign s2          = sgn2 & req_op2[XLEN-1];
    assign abs1        = s1 ? -req_op1 : req_op1;
    assign abs2        = s2 ? -req_op2 : req_op2;
    assign div_zero    = is_div && (req_op2 == '0);
    assign div_ovf     = is_div && !req_op[0] && (req_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_op2 == '1);
    // Overflow quotient equals the dividend itself, so both special cases reuse req_op1
    assign special_res = div_zero ? (req_op[1] ? req_op1 : '1) : (req_op[1] ? '0 : req_op1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] m1, m2, fast_p;
    assign m1       = {{XLEN{s1}}, req_op1};
    assign m2       = {{XLEN{s2}}, req_op2};
    assign fast_p   = m1 * m2;
    assign fast_go  = !is_div;
    assign fast_res = (req_op[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`else
    assign fast_go  = 1'b0;
    assign fast_res = '0;
`endif

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = {rem_q, acc_q[XLEN-1]};
    assign diff     = rem_sh - {2'b00, b_q};
    assign qbit     = !diff[XLEN+1];
    assign rem_n    = qbit ? diff[XLEN:0] : rem_sh[XLEN:0];
    assign quo_n    = {acc_q[XLEN-2:0], qbit};
    assign prod_s   = neg_quo_q ? -mul_next : mul_next;
    assign quo_f    = neg_quo_q ? -quo_n : quo_n;
    assign rem_f    = neg_rem_q ? -rem_n[XLEN-1:0] : rem_n[XLEN-1:0];
    assign busy_res = op_q[2] ? (op_q[1] ? rem_f : quo_f)
                              : ((op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
    assign last     = (cnt_q == CNT_W'(XLEN-1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        b_d       = b_q;
        res_d     = res_q;
        case (state_q)
            IDLE: if (req_valid && !kill) begin
                op_d      = req_op;
                neg_quo_d = s1 ^ s2;
                neg_rem_d = s1;
                cnt_d     = '0;
                b_d       = is_div ? abs2 : abs1;
                acc_d     = {{XLEN{1'b0}}, is_div ? abs1 : abs2};
                rem_d     = '0;
                state_d   = (div_zero || div_ovf || fast_go) ? DONE : BUSY;
                res_d     = (div_zero || div_ovf) ? special_res : (fast_go ? fast_res : res_q);
            end
            BUSY: if (kill) begin
                state_d = IDLE;
            end else begin
                acc_d   = op_q[2] ? {{XLEN{1'b0}}, quo_n} : mul_next;
                rem_d   = op_q[2] ? rem_n : rem_q;
                cnt_d   = last ? cnt_q : cnt_q + 1'b1;
                state_d = last ? DONE : BUSY;
                res_d   = last ? busy_res : res_q;
            end
            DONE: state_d = (kill || resp_ready) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            rem_q     <= '0;
            b_q       <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            b_q       <= b_d;
            res_q     <= res_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == DONE);
    assign resp_result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0, reset_n = 1'b0, req_valid = 1'b0, kill = 1'b0, resp_ready = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_op1 = '0, req_op2 = '0;
    logic        req_ready, resp_valid;
    logic [31:0] resp_result;
    int          total = 0, passed = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2), .kill(kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_op1 = a;
        req_op2 = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        issue(op, a, b);
        n = 1;
        while (!resp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_res"}, resp_result, exp);
    endtask

    task automatic take();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_result", resp_result, 32'd0);
        reset_n = 1'b1;

        run("mul", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT); take();
        run("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT); take();
        run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT); take();
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT); take();
        run("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT); take();
        run("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT); take();
        run("remu", 3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT); take();
        run("divu0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1); take();
        run("rem0", 3'b110, 32'd5, 32'd0, 32'd5, 1); take();
        run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); take();
        run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1); take();

        run("divu", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_result", resp_result, 32'd14);
            check("bp_ready", {31'b0, req_ready}, 32'd0);
            check("bp_valid", {31'b0, resp_valid}, 32'd1);
        end
        take();
        check("bp_ready_after", {31'b0, req_ready}, 32'd1);
        check("bp_valid_after", {31'b0, resp_valid}, 32'd0);

        @(negedge clk);
        req_valid = 1'b1; kill = 1'b1; req_op = 3'b101; req_op1 = 32'd5; req_op2 = 32'd0;
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b0;
        check("killacc_ready", {31'b0, req_ready}, 32'd1);
        check("killacc_valid", {31'b0, resp_valid}, 32'd0);

        issue(3'b101, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_ready", {31'b0, req_ready}, 32'd1);
        check("kill_valid", {31'b0, resp_valid}, 32'd0);
        repeat (40) @(negedge clk);
        check("kill_no_resp", {31'b0, resp_valid}, 32'd0);
        run("mul_after_kill", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT);
        kill = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        kill = 1'b0; resp_ready = 1'b0;
        check("kill_done_valid", {31'b0, resp_valid}, 32'd0);
        check("kill_done_ready", {31'b0, req_ready}, 32'd1);

        issue(3'b100, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
        check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        check("mid_rst_result", resp_result, 32'd0);
        repeat (40) @(negedge clk);
        check("mid_rst_no_resp", {31'b0, resp_valid}, 32'd0);
        run("remu_after_rst", 3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT); take();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
